dwc_inject_stage: RTL and testbench

DWC_INJECT_STAGE -- requirements
Module: dwc_inject_stage

---
 rtl/dwc_pkg.sv | 24 ++
 rtl/dwc_lfsr32.sv | 42 ++++
 rtl/dwc_inject_stage.sv | 138 +++++++++++++
 tb/tb_dwc_inject_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dwc_pkg.sv
// dwc_pkg
// Shared definitions for the fault-injection staging stage:
//   state_t    - handshake FSM encoding (IDLE / LOADED / RELEASE)
//   DEF_SEED   - LFSR seed used after reset and in place of a zero seed
//   LFSR_TAPS  - Galois tap mask of the 32-bit right-shifting LFSR
//   lfsr_step  - one LFSR advance
package dwc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADED  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_SEED  = 32'h0000_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out of position 0
    // folds the tap mask back into the shifted state.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/dwc_lfsr32.sv
// dwc_lfsr32
// 32-bit Galois LFSR that advances every cycle outside reset.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, loads DEF_SEED
//   load  - load seed instead of stepping this cycle
//   seed  - value to load; zero is replaced by DEF_SEED
//   state - current LFSR state (never zero)
module dwc_lfsr32 #(
    parameter logic [31:0] DEF_SEED = dwc_pkg::DEF_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);
    import dwc_pkg::*;

    logic [31:0] state_reg;
    logic [31:0] state_next;

    // The all-zero state is a lock-up point of the LFSR, so a zero seed
    // is substituted with the default seed.
    always_comb begin
        state_next = lfsr_step(state_reg);
        if (load) begin
            state_next = (seed == 32'd0) ? DEF_SEED : seed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DEF_SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/dwc_inject_stage.sv
// dwc_inject_stage
// Stages a CPU result word for a downstream compare block, optionally
// corrupting it with the LFSR state to exercise the fault detector.
// Handshake: cpu_wr -> LOADED (data_set high) -> irq_clear -> RELEASE
// -> ready_in -> IDLE.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   cpu_wr/cpu_wdata- one-cycle write strobe and word from the CPU
//   inject_en       - fault-injection enable
//   inject_period   - inject on every Nth accepted write (0 = never)
//   seed_load/seed  - reseed the LFSR
//   irq_clear       - downstream clear (honoured in LOADED only)
//   ready_in        - downstream release (honoured in RELEASE only)
//   data_set/data_out - staged word valid / staged word
//   busy            - FSM not in IDLE
//   injected        - last captured word was corrupted
//   overrun         - sticky: write arrived while busy
//   inject_count    - saturating count of injected words
//   lfsr_out        - current LFSR state
module dwc_inject_stage #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] DEF_SEED = dwc_pkg::DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              inject_en,
    input  logic [7:0]        inject_period,
    input  logic              seed_load,
    input  logic [31:0]       seed,
    input  logic              irq_clear,
    input  logic              ready_in,
    output logic              data_set,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              injected,
    output logic              overrun,
    output logic [15:0]       inject_count,
    output logic [31:0]       lfsr_out
);
    import dwc_pkg::*;

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        txn_cnt_reg;
    logic [DATA_W-1:0] data_reg;
    logic              injected_reg;
    logic              overrun_reg;
    logic [15:0]       inject_count_reg;

    logic [31:0]       lfsr_state;
    logic [DATA_W-1:0] lfsr_mask;
    logic              accept;
    logic [7:0]        txn_cnt_inc;
    logic              inject_hit;

    dwc_lfsr32 #(
        .DEF_SEED (DEF_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (seed_load),
        .seed  (seed),
        .state (lfsr_state)
    );

    // The mask repeats the 32-bit LFSR state across the data word so any
    // DATA_W gets corrupted over its full width.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign lfsr_mask[gi] = lfsr_state[gi % 32];
    end

    assign accept      = (state_reg == ST_IDLE) && cpu_wr;
    assign txn_cnt_inc = txn_cnt_reg + 8'd1;
    // Period 0 is gated first so the modulo never acts on a zero divisor.
    assign inject_hit  = inject_en && (inject_period != 8'd0) &&
                         ((txn_cnt_inc % inject_period) == 8'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (cpu_wr)    state_next = ST_LOADED;
            ST_LOADED:  if (irq_clear) state_next = ST_RELEASE;
            ST_RELEASE: if (ready_in)  state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Output logic: data_set and busy decode directly from the state
    // register, which gives the one-cycle write-to-valid latency.
    always_comb begin
        data_set = (state_reg == ST_LOADED);
        busy     = (state_reg != ST_IDLE);
    end

    // Capture path and bookkeeping. The injection decision is frozen into
    // data_reg/injected_reg at capture, so later changes to inject_en or
    // inject_period cannot touch the word already staged.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_reg      <= 8'd0;
            data_reg         <= '0;
            injected_reg     <= 1'b0;
            overrun_reg      <= 1'b0;
            inject_count_reg <= 16'd0;
        end else begin
            if (accept) begin
                txn_cnt_reg  <= txn_cnt_inc;
                data_reg     <= inject_hit ? (cpu_wdata ^ lfsr_mask) : cpu_wdata;
                injected_reg <= inject_hit;
                if (inject_hit && (inject_count_reg != 16'hFFFF)) begin
                    inject_count_reg <= inject_count_reg + 16'd1;
                end
            end
            if (cpu_wr && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign data_out     = data_reg;
    assign injected     = injected_reg;
    assign overrun      = overrun_reg;
    assign inject_count = inject_count_reg;
    assign lfsr_out     = lfsr_state;

endmodule

// File: tb/tb_dwc_inject_stage.sv
module tb_dwc_inject_stage;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr;
    logic [31:0] cpu_wdata;
    logic        inject_en;
    logic [7:0]  inject_period;
    logic        seed_load;
    logic [31:0] seed;
    logic        irq_clear;
    logic        ready_in;
    logic        data_set;
    logic [31:0] data_out;
    logic        busy;
    logic        injected;
    logic        overrun;
    logic [15:0] inject_count;
    logic [31:0] lfsr_out;

    dwc_inject_stage #(
        .DATA_W   (32),
        .DEF_SEED (32'h0000_0001)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_wr        (cpu_wr),
        .cpu_wdata     (cpu_wdata),
        .inject_en     (inject_en),
        .inject_period (inject_period),
        .seed_load     (seed_load),
        .seed          (seed),
        .irq_clear     (irq_clear),
        .ready_in      (ready_in),
        .data_set      (data_set),
        .data_out      (data_out),
        .busy          (busy),
        .injected      (injected),
        .overrun       (overrun),
        .inject_count  (inject_count),
        .lfsr_out      (lfsr_out)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped on the same edges as the DUT.
    logic [31:0] lfsr_m;
    always @(posedge clk) begin
        if (rst)            lfsr_m <= 32'h0000_0001;
        else if (seed_load) lfsr_m <= (seed == 32'd0) ? 32'h0000_0001 : seed;
        else                lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ TAPS) : (lfsr_m >> 1);
    end

    typedef struct {
        logic [31:0] data;
        logic        inj;
    } exp_t;

    typedef struct {
        logic [31:0] wdata;
        logic        en;
        logic [7:0]  period;
        logic        exp_inj;
    } vec_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          txn_no   = 0;
    logic [15:0] inj_cnt_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        inj_cnt_m = 16'd0;
        sb.delete();
    endtask

    // Drive one write in IDLE, push the expectation, then check the word
    // that appears one cycle later.
    task automatic do_write(input logic [31:0] w, input logic exp_inj);
        exp_t e;
        @(negedge clk);
        cpu_wr    = 1'b1;
        cpu_wdata = w;
        e.data = exp_inj ? (w ^ lfsr_m) : w;
        e.inj  = exp_inj;
        sb.push_back(e);
        if (exp_inj && inj_cnt_m != 16'hFFFF) inj_cnt_m = inj_cnt_m + 16'd1;
        @(negedge clk);
        cpu_wr = 1'b0;
        txn_no++;
        check("data_set_latency", {31'd0, data_set}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("data_out", data_out, e.data);
            check("injected", {31'd0, injected}, {31'd0, e.inj});
            check("inject_count", {16'd0, inject_count}, {16'd0, inj_cnt_m});
            $display("txn %0d wdata=%h data_out=%h injected=%0d inject_count=%0d",
                     txn_no, w, data_out, injected, inject_count);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("release_data_set", {31'd0, data_set}, 32'd0);
        check("release_busy", {31'd0, busy}, 32'd1);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("lfsr_track", lfsr_out, lfsr_m);
    endtask

    vec_t vecs[6];
    logic p3_exp[6];
    logic [31:0] held;

    initial begin
        vecs[0] = '{32'h1111_1111, 1'b1, 8'd1, 1'b1};
        vecs[1] = '{32'hA5A5_A5A5, 1'b1, 8'd1, 1'b1};
        vecs[2] = '{32'hDEAD_BEEF, 1'b0, 8'd1, 1'b0};
        vecs[3] = '{32'h0000_0000, 1'b1, 8'd0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 1'b1, 8'd2, 1'b1};
        vecs[5] = '{32'h1357_9BDF, 1'b1, 8'd2, 1'b0};
        p3_exp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; cpu_wr = 1'b0; cpu_wdata = '0; inject_en = 1'b0;
        inject_period = 8'd0; seed_load = 1'b0; seed = '0;
        irq_clear = 1'b0; ready_in = 1'b0;
        do_reset();

        // Reset state
        check("rst_data_set", {31'd0, data_set}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_injected", {31'd0, injected}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_inject_count", {16'd0, inject_count}, 32'd0);
        check("rst_lfsr", lfsr_out, 32'h0000_0001);

        // Plain write; ignored strobes in the wrong states.
        ready_in = 1'b1; irq_clear = 1'b1;
        @(negedge clk);
        ready_in = 1'b0; irq_clear = 1'b0;
        check("idle_ignores_strobes", {31'd0, busy}, 32'd0);
        do_write(32'h1234_5678, 1'b0);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check("loaded_ignores_ready", {31'd0, data_set}, 32'd1);
        handshake();

        // Table: counter is 1 here, period/enable vary per entry.
        for (int i = 0; i < 6; i++) begin
            inject_en     = vecs[i].en;
            inject_period = vecs[i].period;
            do_write(vecs[i].wdata, vecs[i].exp_inj);
            handshake();
        end
        check("table_inject_count", {16'd0, inject_count}, 32'd3);

        // Period 3 from a fresh counter: writes 3 and 6 injected.
        do_reset();
        inject_en = 1'b1; inject_period = 8'd3;
        for (int i = 0; i < 6; i++) begin
            do_write(32'h0F0F_0000 + i, p3_exp[i]);
            handshake();
        end
        check("p3_inject_count", {16'd0, inject_count}, 32'd2);

        // Overrun while LOADED, with injection settings changed mid-flight.
        // Counter is 6: write A (7) is clean; if the dropped write leaves
        // the counter alone, write B (8) is injected at period 2.
        inject_period = 8'd2;
        do_write(32'hAAAA_0001, 1'b0);
        held = data_out;
        @(negedge clk);
        cpu_wr = 1'b1; cpu_wdata = 32'h5555_5555;
        inject_en = 1'b0; inject_period = 8'd1;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("overrun_flag", {31'd0, overrun}, 32'd1);
        check("overrun_data_held", data_out, held);
        check("overrun_injected_held", {31'd0, injected}, 32'd0);
        check("overrun_data_set", {31'd0, data_set}, 32'd1);
        handshake();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        inject_en = 1'b1; inject_period = 8'd2;
        do_write(32'hBBBB_0002, 1'b1);
        handshake();

        // Seed loading
        @(negedge clk);
        seed_load = 1'b1; seed = 32'd0;
        @(negedge clk);
        seed = 32'hCAFE_BABE;
        check("zero_seed", lfsr_out, 32'h0000_0001);
        @(negedge clk);
        seed_load = 1'b0;
        check("seed_load", lfsr_out, 32'hCAFE_BABE);
        @(negedge clk);
        check("lfsr_step", lfsr_out, 32'h657F_5D5F);

        // Reset while LOADED, then a normal transaction.
        inject_en = 1'b0;
        do_write(32'h7777_8888, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inj_cnt_m = 16'd0;
        check("mid_rst_data_set", {31'd0, data_set}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        check("mid_rst_lfsr", lfsr_out, 32'h0000_0001);
        do_write(32'h9999_0000, 1'b0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
